// File: rtl/pci_target_ctrl.sv
// pci_target_ctrl
// Target-side transaction controller for the PCI slave. Decodes memory
// read/write address phases against a DEPTH-word window, runs bursts against
// an internal register file, and drives devsel/storage_control for the
// downstream TRDY stage. All state moves on the falling clock edge so it lines
// up with that stage.
//
// Handshake: a data phase completes (a "transfer") on a falling edge where
// irdy_n and trdy_n are both sampled low. Either side may insert wait states
// by holding its ready high; nothing advances until both are low together.

module pci_target_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          DEPTH     = 8,
    parameter int          PTR_W     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_n,
    input  logic        irdy_n,
    input  logic        trdy_n,
    input  logic [3:0]  cbe_n,
    input  logic [31:0] ad_in,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    output logic        devsel,
    output logic        storage_control,
    output logic        stop_n
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        TURN       = 2'd1,
        DATA       = 2'd2,
        DISCONNECT = 2'd3
    } state_t;

    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    state_t             state;
    state_t             state_d;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_d;
    logic [PTR_W-1:0]   ptr_inc;
    logic               is_write;
    logic               is_write_d;
    logic               devsel_d;
    logic               storage_control_d;
    logic               stop_n_d;
    logic               ad_oe_d;
    logic [31:0]        ad_out_d;
    logic               mem_we;

    logic [31:0]        mem [DEPTH];

    logic               xfer;
    logic               addr_hit;
    logic               cmd_rd;
    logic               cmd_wr;
    logic               decode;
    logic               ptr_last;
    logic               master_abort;

    assign xfer         = !irdy_n && !trdy_n;
    assign addr_hit     = (ad_in[31:PTR_W+2] == BASE_ADDR[31:PTR_W+2]);
    assign cmd_rd       = (cbe_n == CMD_MEM_RD);
    assign cmd_wr       = (cbe_n == CMD_MEM_WR);
    assign decode       = !frame_n && addr_hit && (cmd_rd || cmd_wr);
    assign ptr_last     = (ptr == PTR_W'(DEPTH - 1));
    // Master gave up the burst without a data phase pending.
    assign master_abort = frame_n && irdy_n;
    assign ptr_inc      = ptr + 1'b1;

    // State register.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decision.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (decode) begin
                    state_d = cmd_wr ? DATA : TURN;
                end
            end
            TURN: begin
                state_d = master_abort ? IDLE : DATA;
            end
            DATA: begin
                if (xfer) begin
                    if (frame_n) begin
                        state_d = IDLE;
                    end else if (ptr_last) begin
                        state_d = DISCONNECT;
                    end
                end else if (master_abort) begin
                    state_d = IDLE;
                end
            end
            DISCONNECT: begin
                if (frame_n) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and memory write strobe.
    always_comb begin
        ptr_d             = ptr;
        is_write_d        = is_write;
        devsel_d          = devsel;
        storage_control_d = storage_control;
        stop_n_d          = stop_n;
        ad_oe_d           = ad_oe;
        ad_out_d          = ad_out;
        mem_we            = 1'b0;
        case (state)
            IDLE: begin
                devsel_d          = 1'b1;
                storage_control_d = 1'b0;
                stop_n_d          = 1'b1;
                ad_oe_d           = 1'b0;
                if (decode) begin
                    devsel_d          = 1'b0;
                    ptr_d             = ad_in[PTR_W+1:2];
                    is_write_d        = cmd_wr;
                    // Writes accept data right away; reads need a turnaround.
                    storage_control_d = cmd_wr;
                end
            end
            TURN: begin
                if (master_abort) begin
                    devsel_d          = 1'b1;
                    storage_control_d = 1'b0;
                    stop_n_d          = 1'b1;
                    ad_oe_d           = 1'b0;
                end else begin
                    storage_control_d = 1'b1;
                    ad_oe_d           = 1'b1;
                    ad_out_d          = mem[ptr];
                end
            end
            DATA: begin
                if (xfer) begin
                    mem_we = is_write;
                    // The pointer parks on the last word instead of wrapping.
                    if (!ptr_last) begin
                        ptr_d = ptr_inc;
                        if (!is_write) begin
                            ad_out_d = mem[ptr_inc];
                        end
                    end
                    if (frame_n) begin
                        devsel_d          = 1'b1;
                        storage_control_d = 1'b0;
                        stop_n_d          = 1'b1;
                        ad_oe_d           = 1'b0;
                    end else if (ptr_last) begin
                        storage_control_d = 1'b0;
                        stop_n_d          = 1'b0;
                    end
                end else if (master_abort) begin
                    devsel_d          = 1'b1;
                    storage_control_d = 1'b0;
                    stop_n_d          = 1'b1;
                    ad_oe_d           = 1'b0;
                end
            end
            DISCONNECT: begin
                // Lagging transfers from the TRDY stage are simply ignored here.
                if (frame_n) begin
                    devsel_d          = 1'b1;
                    storage_control_d = 1'b0;
                    stop_n_d          = 1'b1;
                    ad_oe_d           = 1'b0;
                end
            end
            default: begin
                devsel_d          = 1'b1;
                storage_control_d = 1'b0;
                stop_n_d          = 1'b1;
                ad_oe_d           = 1'b0;
            end
        endcase
    end

    // Registered outputs and pointer.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr             <= '0;
            is_write        <= 1'b0;
            devsel          <= 1'b1;
            storage_control <= 1'b0;
            stop_n          <= 1'b1;
            ad_oe           <= 1'b0;
            ad_out          <= '0;
        end else begin
            ptr             <= ptr_d;
            is_write        <= is_write_d;
            devsel          <= devsel_d;
            storage_control <= storage_control_d;
            stop_n          <= stop_n_d;
            ad_oe           <= ad_oe_d;
            ad_out          <= ad_out_d;
        end
    end

    // Register file write with per-byte enables; contents survive reset.
    always_ff @(negedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (!cbe_n[i]) begin
                    mem[ptr][8*i +: 8] <= ad_in[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_pci_target_ctrl.sv
// tb_pci_target_ctrl
// Bus-level bench for pci_target_ctrl. Inputs change on the rising edge and
// outputs are sampled there; the DUT acts on the falling edge. A small model
// of the TRDY stage turns devsel/storage_control into trdy_n one falling edge
// later. Read data expectations come from a bench-side copy of the memory.

module tb_pci_target_ctrl;

    logic        clk;
    logic        rst_n;
    logic        frame_n;
    logic        irdy_n;
    logic        trdy_n;
    logic [3:0]  cbe_n;
    logic [31:0] ad_in;
    logic [31:0] ad_out;
    logic        ad_oe;
    logic        devsel;
    logic        storage_control;
    logic        stop_n;

    int          tests;
    int          fails;
    logic [31:0] ref_mem [8];
    logic [2:0]  cur_ptr;
    logic [31:0] exp_q [$];

    pci_target_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_n         (frame_n),
        .irdy_n          (irdy_n),
        .trdy_n          (trdy_n),
        .cbe_n           (cbe_n),
        .ad_in           (ad_in),
        .ad_out          (ad_out),
        .ad_oe           (ad_oe),
        .devsel          (devsel),
        .storage_control (storage_control),
        .stop_n          (stop_n)
    );

    // Clock and reset-related plumbing.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // TRDY stage model: asserts trdy_n one falling edge after devsel && ready.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) trdy_n <= 1'b1;
        else        trdy_n <= !(!devsel && storage_control);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired before the sequence ended");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        cbe_n   = 4'hF;
        ad_in   = 32'h0;
    endtask

    task automatic end_txn();
        idle_bus();
        repeat (2) @(posedge clk);
    endtask

    // Address phase; returns one rising edge after the decode edge.
    task automatic addr_phase(input logic [31:0] addr, input logic [3:0] cmd);
        frame_n = 1'b0;
        irdy_n  = 1'b1;
        ad_in   = addr;
        cbe_n   = cmd;
        cur_ptr = addr[4:2];
        @(posedge clk);
        ad_in   = 32'h0;
        cbe_n   = 4'h0;
    endtask

    task automatic wr_phase(input logic [31:0] d, input logic [3:0] be, input logic last);
        int n;
        frame_n = last;
        irdy_n  = 1'b0;
        ad_in   = d;
        cbe_n   = be;
        n = 0;
        while (trdy_n !== 1'b0 && n < 16) begin
            @(posedge clk);
            n++;
        end
        check("wr_trdy", {31'b0, trdy_n}, 32'h0);
        if (trdy_n === 1'b0) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if (!be[i]) ref_mem[cur_ptr][8*i +: 8] = d[8*i +: 8];
            if (cur_ptr != 3'd7) cur_ptr = cur_ptr + 3'd1;
            @(posedge clk);
        end
    endtask

    task automatic rd_phase(input logic last);
        int n;
        logic [31:0] e;
        exp_q.push_back(ref_mem[cur_ptr]);
        frame_n = last;
        irdy_n  = 1'b0;
        n = 0;
        while (trdy_n !== 1'b0 && n < 16) begin
            @(posedge clk);
            n++;
        end
        check("rd_trdy", {31'b0, trdy_n}, 32'h0);
        e = exp_q.pop_front();
        if (trdy_n === 1'b0) begin
            check("rd_oe", {31'b0, ad_oe}, 32'h1);
            check("rd_data", ad_out, e);
            @(negedge clk);
            if (cur_ptr != 3'd7) cur_ptr = cur_ptr + 3'd1;
            @(posedge clk);
        end
    endtask

    task automatic rd_txn(input logic [31:0] addr, input int nwords);
        addr_phase(addr, 4'b0110);
        for (int i = 0; i < nwords; i++) rd_phase(i == nwords - 1);
        check("rdtxn_end_oe", {31'b0, ad_oe}, 32'h0);
        end_txn();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cur_ptr = 3'd0;
        idle_bus();
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        @(posedge clk);

        check("rst_devsel", {31'b0, devsel}, 32'h1);
        check("rst_sc", {31'b0, storage_control}, 32'h0);
        check("rst_stop", {31'b0, stop_n}, 32'h1);
        check("rst_oe", {31'b0, ad_oe}, 32'h0);
        check("rst_ad_out", ad_out, 32'h0);

        // Fill every word; the last phase lands on DEPTH-1 with frame_n high.
        addr_phase(32'h0000_1000, 4'b0111);
        check("fill_dec_devsel", {31'b0, devsel}, 32'h0);
        for (int i = 0; i < 8; i++) wr_phase($urandom, 4'b0000, i == 7);
        check("fill_end_stop", {31'b0, stop_n}, 32'h1);
        check("fill_end_devsel", {31'b0, devsel}, 32'h1);
        end_txn();

        // Single write of DEADBEEF to word 0.
        addr_phase(32'h0000_1000, 4'b0111);
        check("wr1_dec_devsel", {31'b0, devsel}, 32'h0);
        check("wr1_dec_sc", {31'b0, storage_control}, 32'h1);
        wr_phase(32'hDEAD_BEEF, 4'b0000, 1'b1);
        check("wr1_end_devsel", {31'b0, devsel}, 32'h1);
        check("wr1_end_sc", {31'b0, storage_control}, 32'h0);
        end_txn();

        // Single read of word 0 with turnaround visible.
        addr_phase(32'h0000_1000, 4'b0110);
        check("rd1_turn_sc", {31'b0, storage_control}, 32'h0);
        check("rd1_turn_devsel", {31'b0, devsel}, 32'h0);
        irdy_n = 1'b0;
        @(posedge clk);
        check("rd1_data_sc", {31'b0, storage_control}, 32'h1);
        check("rd1_data_oe", {31'b0, ad_oe}, 32'h1);
        rd_phase(1'b1);
        check("rd1_end_oe", {31'b0, ad_oe}, 32'h0);
        check("rd1_end_devsel", {31'b0, devsel}, 32'h1);
        end_txn();

        // Partial-byte write burst with master wait states between phases.
        addr_phase(32'h0000_1008, 4'b0111);
        wr_phase(32'h1122_3344, 4'b1100, 1'b0);
        irdy_n = 1'b1;
        repeat (2) @(posedge clk);
        check("wrb_wait_devsel", {31'b0, devsel}, 32'h0);
        wr_phase(32'h5566_7788, 4'b0000, 1'b1);
        end_txn();
        rd_txn(32'h0000_1008, 2);

        // Read burst running off the end of the window.
        addr_phase(32'h0000_1018, 4'b0110);
        rd_phase(1'b0);
        rd_phase(1'b0);
        check("rdisc_stop", {31'b0, stop_n}, 32'h0);
        check("rdisc_sc", {31'b0, storage_control}, 32'h0);
        check("rdisc_devsel", {31'b0, devsel}, 32'h0);
        @(posedge clk);
        check("rdisc_lag_stop", {31'b0, stop_n}, 32'h0);
        check("rdisc_lag_ad_out", ad_out, ref_mem[7]);
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        @(posedge clk);
        check("rdisc_exit_stop", {31'b0, stop_n}, 32'h1);
        check("rdisc_exit_devsel", {31'b0, devsel}, 32'h1);
        check("rdisc_exit_oe", {31'b0, ad_oe}, 32'h0);
        end_txn();

        // Write burst off the end: the lagging transfer must not write.
        addr_phase(32'h0000_101C, 4'b0111);
        wr_phase(32'h7777_0007, 4'b0000, 1'b0);
        ad_in = 32'hBAD0_BAD0;
        check("wdisc_stop", {31'b0, stop_n}, 32'h0);
        @(posedge clk);
        check("wdisc_lag_stop", {31'b0, stop_n}, 32'h0);
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        @(posedge clk);
        check("wdisc_exit_stop", {31'b0, stop_n}, 32'h1);
        check("wdisc_exit_devsel", {31'b0, devsel}, 32'h1);
        end_txn();
        rd_txn(32'h0000_101C, 1);

        // Out-of-window write, then an I/O read inside the window.
        addr_phase(32'h0000_2000, 4'b0111);
        check("miss_addr_devsel", {31'b0, devsel}, 32'h1);
        irdy_n = 1'b0;
        ad_in  = 32'hFFFF_FFFF;
        frame_n = 1'b1;
        repeat (3) @(posedge clk);
        check("miss_addr_devsel2", {31'b0, devsel}, 32'h1);
        check("miss_addr_sc", {31'b0, storage_control}, 32'h0);
        end_txn();
        addr_phase(32'h0000_1000, 4'b0010);
        check("miss_cmd_devsel", {31'b0, devsel}, 32'h1);
        end_txn();
        rd_txn(32'h0000_1000, 1);

        // Asynchronous reset in the middle of a write burst.
        addr_phase(32'h0000_1010, 4'b0111);
        wr_phase(32'hA5A5_0004, 4'b0000, 1'b0);
        irdy_n = 1'b1;
        check("mid_pre_devsel", {31'b0, devsel}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_devsel", {31'b0, devsel}, 32'h1);
        check("mid_rst_sc", {31'b0, storage_control}, 32'h0);
        check("mid_rst_stop", {31'b0, stop_n}, 32'h1);
        check("mid_rst_oe", {31'b0, ad_oe}, 32'h0);
        check("mid_rst_ad_out", ad_out, 32'h0);
        idle_bus();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        rd_txn(32'h0000_1010, 2);

        // Read ending at DEPTH-1 with frame_n high is a plain end.
        addr_phase(32'h0000_101C, 4'b0110);
        rd_phase(1'b1);
        check("last_rd_stop", {31'b0, stop_n}, 32'h1);
        check("last_rd_devsel", {31'b0, devsel}, 32'h1);
        end_txn();

        check("exp_q_empty", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
